count_sampler: RTL and testbench



---
 rtl/count_sampler.sv | 148 ++++++++++++++
 tb/tb_count_sampler.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/count_sampler.sv
// Samples an upstream counter, queues each changed value in a small FIFO and
// delivers it over valid/ready; Done_o is sticky once EndVal has been popped.
// Optional build macro OVERFLOW_FLAG_EN adds a sticky Overflow_o port.
module count_sampler #(
  parameter int unsigned     Width  = 32,
  parameter int unsigned     Depth  = 4,
  parameter logic [Width-1:0] EndVal = Width'(64)
) (
  input  logic                       Clk_i,
  input  logic                       Reset_n_i,
  input  logic [Width-1:0]           Data_i,
  output logic                       Valid_o,
  output logic [Width-1:0]           Data_o,
  input  logic                       Ready_i,
  output logic [$clog2(Depth+1)-1:0] Level_o,
  output logic                       Done_o
`ifdef OVERFLOW_FLAG_EN
  ,
  output logic                       Overflow_o
`endif
);

  localparam int unsigned PW = $clog2(Depth);
  localparam int unsigned LW = $clog2(Depth + 1);

  localparam logic [1:0] ST_INIT   = 2'd0;
  localparam logic [1:0] ST_RUN    = 2'd1;
  localparam logic [1:0] ST_FINISH = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [Width-1:0] prev_q, prev_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             done_q, done_d;
  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] mem_d [Depth];

  logic             valid;
  logic             full;
  logic             pop;
  logic             push_req;
  logic             push_ok;
  logic [Width-1:0] head;

  always_comb begin
    valid    = (level_q != '0);
    full     = (level_q == LW'(Depth));
    head     = mem_q[rd_ptr_q];
    pop      = valid && Ready_i;
    push_req = 1'b0;
    state_d  = state_q;
    prev_d   = prev_q;
    done_d   = done_q;

    case (state_q)
      ST_INIT: begin
        push_req = 1'b1;
        prev_d   = Data_i;
        state_d  = (Data_i == EndVal) ? ST_FINISH : ST_RUN;
      end
      ST_RUN: begin
        // Prev is updated on every attempted push, so a dropped value is not retried.
        if (Data_i != prev_q) begin
          push_req = 1'b1;
          prev_d   = Data_i;
          if (Data_i == EndVal) state_d = ST_FINISH;
        end
      end
      ST_FINISH: begin
        if (pop && (head == EndVal)) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end
      end
      default: begin
        done_d = 1'b1;
      end
    endcase

    // A full FIFO still accepts a push when the head leaves at the same edge.
    push_ok = push_req && (!full || pop);
  end

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = Data_i;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push_ok, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge Clk_i or negedge Reset_n_i) begin
    if (!Reset_n_i) begin
      state_q  <= ST_INIT;
      prev_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      done_q   <= 1'b0;
      for (int unsigned i = 0; i < Depth; i++) mem_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      prev_q   <= prev_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      done_q   <= done_d;
      for (int unsigned i = 0; i < Depth; i++) mem_q[i] <= mem_d[i];
    end
  end

  assign Valid_o = valid;
  assign Data_o  = valid ? head : '0;
  assign Level_o = level_q;
  assign Done_o  = done_q;

`ifdef OVERFLOW_FLAG_EN
  logic ovf_q, ovf_d;

  always_comb begin
    ovf_d = ovf_q || (push_req && !push_ok);
  end

  always_ff @(posedge Clk_i or negedge Reset_n_i) begin
    if (!Reset_n_i) ovf_q <= 1'b0;
    else            ovf_q <= ovf_d;
  end

  assign Overflow_o = ovf_q;

  a_no_drop_below_full: assert property (
    @(posedge Clk_i) disable iff (!Reset_n_i)
    (push_req && (level_q < LW'(Depth))) |-> push_ok
  );
`endif

endmodule

// File: tb/tb_count_sampler.sv
// Scoreboard bench for count_sampler: expected pops are queued as stimulus is
// driven and compared by a negedge monitor whenever Valid_o && Ready_i.
module tb_count_sampler;

  logic        Clk_i;
  logic        Reset_n_i;
  logic [31:0] Data_i;
  logic        Valid_o;
  logic [31:0] Data_o;
  logic        Ready_i;
  logic [2:0]  Level_o;
  logic        Done_o;
`ifdef OVERFLOW_FLAG_EN
  logic        Overflow_o;
`endif

  int unsigned n_chk = 0;
  int unsigned n_err = 0;
  logic [31:0] exp_q[$];

  count_sampler #(.Width(32), .Depth(4), .EndVal(32'd64)) dut (
    .Clk_i     (Clk_i),
    .Reset_n_i (Reset_n_i),
    .Data_i    (Data_i),
    .Valid_o   (Valid_o),
    .Data_o    (Data_o),
    .Ready_i   (Ready_i),
    .Level_o   (Level_o),
    .Done_o    (Done_o)
`ifdef OVERFLOW_FLAG_EN
    ,
    .Overflow_o(Overflow_o)
`endif
  );

  initial Clk_i = 1'b0;
  always #5 Clk_i = ~Clk_i;

  // Inputs only change at posedge+1, so the negedge view matches the next edge.
  always @(negedge Clk_i) begin
    if (Reset_n_i && Valid_o && Ready_i) begin
      n_chk++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL pop_unexpected: Data_o=%0d popped, required no entry", Data_o);
      end else begin
        logic [31:0] exp;
        exp = exp_q.pop_front();
        if (Data_o !== exp) begin
          n_err++;
          $display("FAIL pop_data: Data_o=%0d, required %0d", Data_o, exp);
        end
      end
    end
  end

  task automatic tick();
    @(posedge Clk_i);
    #1;
  endtask

  task automatic do_reset();
    Reset_n_i = 1'b0;
    Ready_i   = 1'b0;
    Data_i    = '0;
    exp_q.delete();
    repeat (3) tick();
    Reset_n_i = 1'b1;
  endtask

  task automatic test_reset();
    Reset_n_i = 1'b0;
    Ready_i   = 1'b1;
    Data_i    = 32'd8;
    exp_q.delete();
    repeat (3) tick();
    n_chk++;
    if ({Valid_o, Data_o, Level_o, Done_o} !== '0) begin
      n_err++;
      $display("FAIL reset_state: V=%b D=%0d L=%0d Done=%b, required all 0",
               Valid_o, Data_o, Level_o, Done_o);
    end
    Reset_n_i = 1'b1;
  endtask

  task automatic test_stream();
    do_reset();
    Ready_i = 1'b1;
    for (int v = 8; v <= 64; v++) begin
      Data_i = v;
      exp_q.push_back(v);
      tick();
      n_chk++;
      if (Level_o > 3'd1 || Valid_o !== 1'b1) begin
        n_err++;
        $display("FAIL stream_level: v=%0d L=%0d V=%b, required L=1 V=1", v, Level_o, Valid_o);
      end
    end
    n_chk++;
    if (Done_o !== 1'b0) begin
      n_err++;
      $display("FAIL stream_done_early: Done_o=%b, required 0", Done_o);
    end
    tick();
    n_chk++;
    if (Done_o !== 1'b1 || Level_o !== 3'd0 || exp_q.size() != 0) begin
      n_err++;
      $display("FAIL stream_done: Done_o=%b L=%0d left=%0d, required 1 0 0",
               Done_o, Level_o, exp_q.size());
    end
`ifdef OVERFLOW_FLAG_EN
    n_chk++;
    if (Overflow_o !== 1'b0) begin
      n_err++;
      $display("FAIL stream_ovf: Overflow_o=%b, required 0", Overflow_o);
    end
`endif
    Ready_i = 1'b0;
  endtask

  task automatic test_overflow();
    do_reset();
    for (int v = 8; v <= 13; v++) begin
      Data_i = v;
      if (v <= 11) exp_q.push_back(v);
      tick();
    end
    n_chk++;
    if (Level_o !== 3'd4 || Data_o !== 32'd8) begin
      n_err++;
      $display("FAIL ovf_full: L=%0d D=%0d, required L=4 D=8", Level_o, Data_o);
    end
`ifdef OVERFLOW_FLAG_EN
    n_chk++;
    if (Overflow_o !== 1'b1) begin
      n_err++;
      $display("FAIL ovf_flag: Overflow_o=%b, required 1", Overflow_o);
    end
`endif
    Ready_i = 1'b1;
    repeat (5) tick();
    n_chk++;
    if (Level_o !== 3'd0 || Valid_o !== 1'b0 || Data_o !== 32'd0 || exp_q.size() != 0) begin
      n_err++;
      $display("FAIL ovf_drain: L=%0d V=%b D=%0d left=%0d, required 0 0 0 0",
               Level_o, Valid_o, Data_o, exp_q.size());
    end
    Ready_i = 1'b0;
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int v = 8; v <= 11; v++) begin
      Data_i = v;
      exp_q.push_back(v);
      tick();
    end
    Data_i  = 32'd12;
    exp_q.push_back(32'd12);
    Ready_i = 1'b1;
    tick();
    Ready_i = 1'b0;
    n_chk++;
    if (Level_o !== 3'd4 || Data_o !== 32'd9) begin
      n_err++;
      $display("FAIL full_push_pop: L=%0d D=%0d, required L=4 D=9", Level_o, Data_o);
    end
    Ready_i = 1'b1;
    repeat (4) tick();
    n_chk++;
    if (Level_o !== 3'd0 || exp_q.size() != 0) begin
      n_err++;
      $display("FAIL full_push_pop_drain: L=%0d left=%0d, required 0 0", Level_o, exp_q.size());
    end
    Ready_i = 1'b0;
  endtask

  task automatic test_hold();
    do_reset();
    Data_i = 32'd8;
    exp_q.push_back(32'd8);
    repeat (10) tick();
    n_chk++;
    if (Level_o !== 3'd1 || Data_o !== 32'd8) begin
      n_err++;
      $display("FAIL hold_single: L=%0d D=%0d, required L=1 D=8", Level_o, Data_o);
    end
    Ready_i = 1'b1;
    tick();
    Ready_i = 1'b0;
    Data_i  = 32'd64;
    exp_q.push_back(32'd64);
    repeat (5) tick();
    Data_i = 32'd20;
    repeat (3) tick();
    n_chk++;
    if (Level_o !== 3'd1 || Data_o !== 32'd64 || Done_o !== 1'b0) begin
      n_err++;
      $display("FAIL hold_finish: L=%0d D=%0d Done=%b, required L=1 D=64 Done=0",
               Level_o, Data_o, Done_o);
    end
    Ready_i = 1'b1;
    tick();
    Ready_i = 1'b0;
    n_chk++;
    if (Done_o !== 1'b1 || Level_o !== 3'd0 || exp_q.size() != 0) begin
      n_err++;
      $display("FAIL hold_done: Done=%b L=%0d left=%0d, required 1 0 0",
               Done_o, Level_o, exp_q.size());
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int v = 8; v <= 10; v++) begin
      Data_i = v;
      exp_q.push_back(v);
      tick();
    end
    n_chk++;
    if (Level_o !== 3'd3) begin
      n_err++;
      $display("FAIL areset_pre: L=%0d, required 3", Level_o);
    end
    #2;
    Reset_n_i = 1'b0;
    #1;
    n_chk++;
    if ({Valid_o, Data_o, Level_o, Done_o} !== '0) begin
      n_err++;
      $display("FAIL areset_async: V=%b D=%0d L=%0d Done=%b, required all 0",
               Valid_o, Data_o, Level_o, Done_o);
    end
    exp_q.delete();
    tick();
    Reset_n_i = 1'b1;
    Data_i    = 32'd8;
    exp_q.push_back(32'd8);
    tick();
    n_chk++;
    if (Level_o !== 3'd1 || Data_o !== 32'd8) begin
      n_err++;
      $display("FAIL areset_init: L=%0d D=%0d, required L=1 D=8", Level_o, Data_o);
    end
    Ready_i = 1'b1;
    tick();
    Ready_i = 1'b0;
    n_chk++;
    if (Level_o !== 3'd0 || exp_q.size() != 0) begin
      n_err++;
      $display("FAIL areset_drain: L=%0d left=%0d, required 0 0", Level_o, exp_q.size());
    end
  endtask

  task automatic test_endval_first();
    do_reset();
    Data_i = 32'd64;
    exp_q.push_back(32'd64);
    tick();
    Data_i = 32'd65;
    tick();
    n_chk++;
    if (Level_o !== 3'd1 || Data_o !== 32'd64 || Done_o !== 1'b0) begin
      n_err++;
      $display("FAIL endval_init: L=%0d D=%0d Done=%b, required L=1 D=64 Done=0",
               Level_o, Data_o, Done_o);
    end
    Ready_i = 1'b1;
    tick();
    n_chk++;
    if (Done_o !== 1'b1 || Level_o !== 3'd0) begin
      n_err++;
      $display("FAIL endval_done: Done=%b L=%0d, required Done=1 L=0", Done_o, Level_o);
    end
    Data_i = 32'd7;
    repeat (2) tick();
    n_chk++;
    if (Done_o !== 1'b1 || Level_o !== 3'd0 || exp_q.size() != 0) begin
      n_err++;
      $display("FAIL endval_sticky: Done=%b L=%0d left=%0d, required 1 0 0",
               Done_o, Level_o, exp_q.size());
    end
    Ready_i = 1'b0;
  endtask

  initial begin
    Reset_n_i = 1'b0;
    Ready_i   = 1'b0;
    Data_i    = '0;
    test_reset();
    test_stream();
    test_overflow();
    test_back_to_back();
    test_hold();
    test_async_reset();
    test_endval_first();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
